// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side connection bundle for the hazard controller: register fields and
// write enables in, stall/forwarding controls and statistics out.
interface pipeline_hazard_ctrl_if #(
  parameter int STAT_W = 16
);
  logic [4:0]        id_rs;
  logic [4:0]        id_rt;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic [4:0]        ex_rd;
  logic              ex_rf_enable;
  logic              ex_load_instr;
  logic [4:0]        mem_rd;
  logic              mem_rf_enable;
  logic [4:0]        wb_rd;
  logic              wb_rf_enable;
  logic              clr_stats;
  logic              pc_le;
  logic              npc_le;
  logic              ifid_le;
  logic              nop_sel;
  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;
  logic              stalled;
  logic [STAT_W-1:0] stall_count;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt,
    output ex_rd, ex_rf_enable, ex_load_instr,
    output mem_rd, mem_rf_enable, wb_rd, wb_rf_enable, clr_stats,
    input  pc_le, npc_le, ifid_le, nop_sel, fwd_a_sel, fwd_b_sel,
    input  stalled, stall_count
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt,
    input  ex_rd, ex_rf_enable, ex_load_instr,
    input  mem_rd, mem_rf_enable, wb_rd, wb_rf_enable, clr_stats,
    output pc_le, npc_le, ifid_le, nop_sel, fwd_a_sel, fwd_b_sel,
    output stalled, stall_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage PPU pipeline: load-use stall sequencing,
// EX/MEM/WB forwarding selects and a saturating bubble counter.
// Optional macro HAZARD_FORWARDING_EN enables forwarding; without it every
// RAW match against EX/MEM/WB stalls instead.
module pipeline_hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int STAT_W            = 16
) (
  input logic                   clk,
  input logic                   reset,
  pipeline_hazard_ctrl_if.slave hz
);

  typedef enum logic {RUN, STALL} state_t;

  state_t            state, state_nxt;
  logic [2:0]        cnt, cnt_nxt;
  logic              stall;
  logic              stall_g;
  logic              load_use;
  logic              rs_ex, rs_mem, rs_wb;
  logic              rt_ex, rt_mem, rt_wb;
  logic [1:0]        fwd_a, fwd_b;
  logic [STAT_W-1:0] stall_count;

  // Register 0 is hardwired, so it never creates a dependency.
  function automatic logic reg_match(input logic used, input logic wr_en,
                                     input logic [4:0] src, input logic [4:0] dst);
    return used & wr_en & (dst != 5'd0) & (src == dst);
  endfunction

  function automatic logic [1:0] fwd_pick(input logic ex_m, input logic mem_m,
                                          input logic wb_m, input logic ex_load);
    logic [1:0] sel;
    sel = 2'b00;
    if (ex_m && !ex_load) sel = 2'b01;
    else if (mem_m)       sel = 2'b10;
    else if (wb_m)        sel = 2'b11;
    return sel;
  endfunction

  assign rs_ex  = reg_match(hz.id_uses_rs, hz.ex_rf_enable,  hz.id_rs, hz.ex_rd);
  assign rs_mem = reg_match(hz.id_uses_rs, hz.mem_rf_enable, hz.id_rs, hz.mem_rd);
  assign rs_wb  = reg_match(hz.id_uses_rs, hz.wb_rf_enable,  hz.id_rs, hz.wb_rd);
  assign rt_ex  = reg_match(hz.id_uses_rt, hz.ex_rf_enable,  hz.id_rt, hz.ex_rd);
  assign rt_mem = reg_match(hz.id_uses_rt, hz.mem_rf_enable, hz.id_rt, hz.mem_rd);
  assign rt_wb  = reg_match(hz.id_uses_rt, hz.wb_rf_enable,  hz.id_rt, hz.wb_rd);

  assign load_use = hz.ex_load_instr & (rs_ex | rt_ex);

`ifdef HAZARD_FORWARDING_EN
  logic raw_stall;
  assign raw_stall = 1'b0;
  assign fwd_a     = fwd_pick(rs_ex, rs_mem, rs_wb, hz.ex_load_instr);
  assign fwd_b     = fwd_pick(rt_ex, rt_mem, rt_wb, hz.ex_load_instr);
`else
  logic raw_stall;
  assign raw_stall = rs_ex | rs_mem | rs_wb | rt_ex | rt_mem | rt_wb;
  assign fwd_a     = 2'b00;
  assign fwd_b     = 2'b00;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Mealy outputs: the bubble for a new hazard is issued in the cycle it is seen.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall     = 1'b0;
    case (state)
      RUN: begin
        if (load_use) begin
          stall = 1'b1;
          if (LOAD_STALL_CYCLES > 1) begin
            state_nxt = STALL;
            cnt_nxt   = 3'(LOAD_STALL_CYCLES - 1);
          end
        end else if (raw_stall) begin
          stall = 1'b1;
        end
      end
      STALL: begin
        // The load has already moved past EX, so load_use is not re-examined here.
        stall   = 1'b1;
        cnt_nxt = cnt - 3'd1;
        if (cnt == 3'd1) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // Outputs are forced to run values while reset is held, even with hazards present.
  assign stall_g = stall & reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_count <= '0;
    else if (hz.clr_stats)
      stall_count <= '0;
    else if (stall_g && (stall_count != {STAT_W{1'b1}}))
      stall_count <= stall_count + 1'b1;
  end

  assign hz.pc_le       = ~stall_g;
  assign hz.npc_le      = ~stall_g;
  assign hz.ifid_le     = ~stall_g;
  assign hz.nop_sel     = stall_g;
  assign hz.stalled     = stall_g;
  assign hz.fwd_a_sel   = fwd_a & {2{reset}};
  assign hz.fwd_b_sel   = fwd_b & {2{reset}};
  assign hz.stall_count = stall_count;

endmodule
